// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch constants, fetch FSM states and
// IF/ID register control encoding.
package mips_pkg;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
   localparam logic [31:0] PC_INCR    = 32'd4;
   localparam int unsigned IMEM_IDX_W = 10;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   // IF/ID update commands issued by the fetch control.
   typedef enum logic [1:0] {
      IFID_HOLD   = 2'd0,
      IFID_LOAD   = 2'd1,
      IFID_FLUSH  = 2'd2,
      IFID_BUBBLE = 2'd3
   } ifid_cmd_e;

   function automatic logic is_word_aligned(input logic [31:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: captures the fetched word and its PC+4, or turns
// into a bubble on flush (nop loaded) or bubble (data kept, valid cleared).
module if_id_register
   import mips_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  ifid_cmd_e   cmd_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_plus4_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_plus4_o,
   output logic        valid_o
);

   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic        valid_q, valid_d;

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned and infers a latch.
   always_comb begin
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      unique case (cmd_i)
         IFID_LOAD: begin
            instr_d    = instr_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
         end
         IFID_FLUSH: begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end
         IFID_BUBBLE: valid_d = 1'b0;
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // sample their D-inputs simultaneously at the edge.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         instr_q    <= NOP_INSTR;
         pc_plus4_q <= 32'h0;
         valid_q    <= 1'b0;
      end else begin
         instr_q    <= instr_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
      end
   end

   assign instr_o    = instr_q;
   assign pc_plus4_o = pc_plus4_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS instruction fetch: PC, fetch FSM and fetch counter in front of the
// IF/ID register. Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects.
module instruction_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 1024
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   output logic [31:0] ImemAddress,
   input  logic [31:0] ImemInstruction,
   output logic [31:0] IfIdInstruction,
   output logic [31:0] IfIdPCPlus4,
   output logic        IfIdValid,
   output logic [31:0] FetchCount,
   output logic        FetchFault
);

   // The memory decodes PC[11:2]; any other depth or a misaligned reset PC
   // would break that contract.
   if (IMEM_WORDS != (1 << IMEM_IDX_W) || !is_word_aligned(RESET_PC)) begin : g_bad_config
      $error("instruction_fetch_unit: unsupported IMEM_WORDS or misaligned RESET_PC");
   end

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  count_q, count_d;
   logic [31:0]  pc_plus4;
   ifid_cmd_e    ifid_cmd;

`ifdef FETCH_ALIGN_CHECK_EN
   logic fault_q, fault_d;
`endif

   assign pc_plus4 = pc_q + PC_INCR;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      count_d  = count_q;
      ifid_cmd = IFID_HOLD;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_d  = fault_q;
`endif
      unique case (state_q)
         RUN: begin
            if (BranchTaken) begin
               ifid_cmd = IFID_FLUSH;
`ifdef FETCH_ALIGN_CHECK_EN
               if (!is_word_aligned(BranchTarget)) begin
                  fault_d = 1'b1;
                  state_d = HALT;
               end else begin
                  pc_d = BranchTarget;
               end
`else
               pc_d = BranchTarget & ~32'h3;
`endif
            end else if (!Stall) begin
               pc_d     = pc_plus4;
               count_d  = count_q + 32'd1;
               ifid_cmd = IFID_LOAD;
            end
         end
         HALT: ifid_cmd = IFID_BUBBLE;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         count_q <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge Clk) begin
      if (!Reset) fault_q <= 1'b0;
      else        fault_q <= fault_d;
   end
   assign FetchFault = fault_q;
`else
   assign FetchFault = 1'b0;
`endif

   if_id_register u_if_id (
      .clk_i      (Clk),
      .rst_ni     (Reset),
      .cmd_i      (ifid_cmd),
      .instr_i    (ImemInstruction),
      .pc_plus4_i (pc_plus4),
      .instr_o    (IfIdInstruction),
      .pc_plus4_o (IfIdPCPlus4),
      .valid_o    (IfIdValid)
   );

   assign ImemAddress = pc_q;
   assign FetchCount  = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: the driver pushes hand-computed
// post-edge state per cycle; a monitor pops and compares at the falling edge.
module tb_instruction_fetch_unit;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic [31:0] count;
      logic        fault;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Stall;
   logic        BranchTaken;
   logic [31:0] BranchTarget;
   logic [31:0] ImemAddress;
   logic [31:0] ImemInstruction;
   logic [31:0] IfIdInstruction;
   logic [31:0] IfIdPCPlus4;
   logic        IfIdValid;
   logic [31:0] FetchCount;
   logic        FetchFault;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 Clk = ~Clk;

   // Instruction memory model: word i holds i*3, indexed by address bits [11:2].
   always_comb ImemInstruction = {22'h0, ImemAddress[11:2]} * 32'd3;

   instruction_fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_WORDS (1024)
   ) dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .Stall           (Stall),
      .BranchTaken     (BranchTaken),
      .BranchTarget    (BranchTarget),
      .ImemAddress     (ImemAddress),
      .ImemInstruction (ImemInstruction),
      .IfIdInstruction (IfIdInstruction),
      .IfIdPCPlus4     (IfIdPCPlus4),
      .IfIdValid       (IfIdValid),
      .FetchCount      (FetchCount),
      .FetchFault      (FetchFault)
   );

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Apply one cycle of inputs and record the state expected after the edge.
   task automatic vec(input logic rst, input logic stall, input logic br, input logic [31:0] tgt,
                      input logic [31:0] e_pc, input logic [31:0] e_instr, input logic [31:0] e_pc4,
                      input logic e_valid, input logic [31:0] e_count, input logic e_fault);
      exp_t e;
      Reset        = rst;
      Stall        = stall;
      BranchTaken  = br;
      BranchTarget = tgt;
      @(posedge Clk);
      e.pc = e_pc; e.instr = e_instr; e.pc4 = e_pc4;
      e.valid = e_valid; e.count = e_count; e.fault = e_fault;
      exp_q.push_back(e);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge Clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("imem_address", ImemAddress, e.pc);
            check("ifid_instr", IfIdInstruction, e.instr);
            check("ifid_pc_plus4", IfIdPCPlus4, e.pc4);
            check("ifid_valid", {31'h0, IfIdValid}, {31'h0, e.valid});
            check("fetch_count", FetchCount, e.count);
            check("fetch_fault", {31'h0, FetchFault}, {31'h0, e.fault});
         end
      end
   end

   initial begin : driver
      Reset = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
      //   rst stall br  target         pc             instr  pc4            v  count fault
      vec(0, 0, 0, 32'h0,          32'h0,         0,     32'h0,         0, 0,  0);
      vec(0, 0, 0, 32'h0,          32'h0,         0,     32'h0,         0, 0,  0);
      vec(1, 0, 0, 32'h0,          32'h4,         0,     32'h4,         1, 1,  0);
      vec(1, 0, 0, 32'h0,          32'h8,         3,     32'h8,         1, 2,  0);
      vec(1, 0, 0, 32'h0,          32'hC,         6,     32'hC,         1, 3,  0);
      vec(1, 0, 0, 32'h0,          32'h10,        9,     32'h10,        1, 4,  0);
      vec(1, 1, 0, 32'h0,          32'h10,        9,     32'h10,        1, 4,  0);
      vec(1, 1, 0, 32'h0,          32'h10,        9,     32'h10,        1, 4,  0);
      vec(1, 0, 0, 32'h0,          32'h14,        12,    32'h14,        1, 5,  0);
      vec(1, 1, 1, 32'h40,         32'h40,        0,     32'h14,        0, 5,  0);
      vec(1, 0, 0, 32'h0,          32'h44,        48,    32'h44,        1, 6,  0);
      vec(1, 0, 1, 32'hFF8,        32'hFF8,       0,     32'h44,        0, 6,  0);
      vec(1, 0, 0, 32'h0,          32'hFFC,       3066,  32'hFFC,       1, 7,  0);
      vec(1, 0, 0, 32'h0,          32'h1000,      3069,  32'h1000,      1, 8,  0);
      vec(1, 0, 0, 32'h0,          32'h1004,      0,     32'h1004,      1, 9,  0);
      vec(1, 0, 1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 0,     32'h1004,      0, 9,  0);
      vec(1, 0, 0, 32'h0,          32'h0,         3069,  32'h0,         1, 10, 0);
`ifdef FETCH_ALIGN_CHECK_EN
      vec(1, 0, 1, 32'h42,         32'h0,         0,     32'h0,         0, 10, 1);
      vec(1, 0, 0, 32'h0,          32'h0,         0,     32'h0,         0, 10, 1);
      vec(1, 1, 1, 32'h80,         32'h0,         0,     32'h0,         0, 10, 1);
`else
      vec(1, 0, 1, 32'h42,         32'h40,        0,     32'h0,         0, 10, 0);
      vec(1, 0, 0, 32'h0,          32'h44,        48,    32'h44,        1, 11, 0);
      vec(1, 1, 1, 32'h80,         32'h80,        0,     32'h44,        0, 11, 0);
`endif
      vec(0, 0, 1, 32'h100,        32'h0,         0,     32'h0,         0, 0,  0);
      vec(1, 0, 0, 32'h0,          32'h4,         0,     32'h4,         1, 1,  0);
      vec(0, 1, 0, 32'h0,          32'h0,         0,     32'h0,         0, 0,  0);

      for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge Clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
